// File: rtl/pong_pkg.sv
// Shared types for the pong match controller: FSM state codes, winner encoding
// and score width, plus a saturating score increment.
package pong_pkg;

  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  // Scores stick at the maximum instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the raw active-low VGA vsync into the clkin domain and emits a
// one-cycle frame_tick on every falling edge (3 clkin cycles after the edge).
module frame_tick_gen (
  input  logic clkin,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_tick;

  // Flops preset to 1 so reset release never looks like a vsync falling edge.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= vsync;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_prev & ~r_sync2;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve hold, play, point pause and game-over handling,
// with per-player scoring and the ball-recentre pulse.
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               vsync,
  input  logic               start,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [2:0]         state,
  output logic               physics_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [1:0]         winner,
  output logic               frame_tick
);

  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             r_state, w_state_next;
  logic [7:0]         r_frame_cnt, w_frame_cnt_next;
  logic [SCORE_W-1:0] r_p1_score, w_p1_score_next;
  logic [SCORE_W-1:0] r_p2_score, w_p2_score_next;
  logic               r_serve_dir, w_serve_dir_next;
  winner_t            r_winner, w_winner_next;
  logic               r_ball_reset, w_ball_reset_next;
  logic               r_physics_en;
  logic               r_start_prev;
  logic               w_start_rise;
  logic               w_frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .clkin      (clkin),
    .rst        (rst),
    .vsync      (vsync),
    .frame_tick (w_frame_tick)
  );

  // History preset to 1: a start held through reset must drop before it counts.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) r_start_prev <= 1'b1;
    else     r_start_prev <= start;
  end

  assign w_start_rise = start & ~r_start_prev;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_frame_cnt  <= 8'd0;
      r_p1_score   <= '0;
      r_p2_score   <= '0;
      r_serve_dir  <= 1'b0;
      r_winner     <= WIN_NONE;
      r_ball_reset <= 1'b0;
      r_physics_en <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_p1_score   <= w_p1_score_next;
      r_p2_score   <= w_p2_score_next;
      r_serve_dir  <= w_serve_dir_next;
      r_winner     <= w_winner_next;
      r_ball_reset <= w_ball_reset_next;
      r_physics_en <= (w_state_next == ST_PLAY);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_frame_cnt_next  = r_frame_cnt;
    w_p1_score_next   = r_p1_score;
    w_p2_score_next   = r_p2_score;
    w_serve_dir_next  = r_serve_dir;
    w_winner_next     = r_winner;
    w_ball_reset_next = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_next      = ST_SERVE;
          w_p1_score_next   = '0;
          w_p2_score_next   = '0;
          w_serve_dir_next  = 1'b0;
          w_winner_next     = WIN_NONE;
          w_ball_reset_next = 1'b1;
        end
      end

      ST_SERVE: begin
        if (w_frame_tick) begin
          if (r_frame_cnt == SERVE_LAST) w_state_next = ST_PLAY;
          else                           w_frame_cnt_next = r_frame_cnt + 8'd1;
        end
      end

      ST_PLAY: begin
        unique case ({goal_left, goal_right})
          2'b10: begin
            w_p2_score_next  = score_inc(r_p2_score);
            w_serve_dir_next = 1'b0;
            w_state_next     = ST_POINT;
          end
          2'b01: begin
            w_p1_score_next  = score_inc(r_p1_score);
            w_serve_dir_next = 1'b1;
            w_state_next     = ST_POINT;
          end
          // Simultaneous exits are a wash: nobody scores, the rally is re-served.
          2'b11: begin
            w_state_next      = ST_SERVE;
            w_ball_reset_next = 1'b1;
          end
          default: ;
        endcase
      end

      ST_POINT: begin
        if (w_frame_tick) begin
          if (r_frame_cnt == POINT_LAST) begin
            if (r_p1_score == WIN_VAL) begin
              w_state_next  = ST_GAME_OVER;
              w_winner_next = WIN_P1;
            end else if (r_p2_score == WIN_VAL) begin
              w_state_next  = ST_GAME_OVER;
              w_winner_next = WIN_P2;
            end else begin
              w_state_next      = ST_SERVE;
              w_ball_reset_next = 1'b1;
            end
          end else begin
            w_frame_cnt_next = r_frame_cnt + 8'd1;
          end
        end
      end

      ST_GAME_OVER: begin
        if (w_start_rise) w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase

    // Every state entry restarts the frame count for the hold/pause windows.
    if (w_state_next != r_state) w_frame_cnt_next = 8'd0;
  end

  assign state         = r_state;
  assign physics_en    = r_physics_en;
  assign ball_reset    = r_ball_reset;
  assign serve_dir     = r_serve_dir;
  assign player1_score = r_p1_score;
  assign player2_score = r_p2_score;
  assign winner        = r_winner;
  assign frame_tick    = w_frame_tick;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short serve/point windows and a
// first-to-3 match.
module tb_match_controller;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       goal_left = 1'b0;
  logic       goal_right = 1'b0;
  logic [2:0] state;
  logic       physics_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [7:0] player1_score;
  logic [7:0] player2_score;
  logic [1:0] winner;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  match_controller #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .POINT_FRAMES (2)
  ) dut (
    .clkin         (clkin),
    .rst           (rst),
    .vsync         (vsync),
    .start         (start),
    .goal_left     (goal_left),
    .goal_right    (goal_right),
    .state         (state),
    .physics_en    (physics_en),
    .ball_reset    (ball_reset),
    .serve_dir     (serve_dir),
    .player1_score (player1_score),
    .player2_score (player2_score),
    .winner        (winner),
    .frame_tick    (frame_tick)
  );

  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clkin);
  endtask

  // Raise vsync long enough to be seen, then drop it; returns on the negedge
  // where the tick-triggered FSM update is first visible.
  task automatic send_frame();
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    tests++; if (physics_en !== 1'b0) begin fails++; $display("FAIL reset_physics: got %b expected 0", physics_en); end
    tests++; if (ball_reset !== 1'b0) begin fails++; $display("FAIL reset_ball_reset: got %b expected 0", ball_reset); end
    tests++; if (serve_dir !== 1'b0) begin fails++; $display("FAIL reset_serve_dir: got %b expected 0", serve_dir); end
    tests++; if (player1_score !== 8'd0 || player2_score !== 8'd0) begin fails++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", player1_score, player2_score); end
    tests++; if (winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %b expected 00", winner); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
    rst = 1'b0;
    repeat (2) cyc();
    $display("[TB] test_reset done");
  endtask

  task automatic test_frame_tick();
    vsync = 1'b0;
    cyc();
    cyc();
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL tick_early: got %b expected 0 two cycles after edge", frame_tick); end
    cyc();
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL tick_latency: got %b expected 1 three cycles after edge", frame_tick); end
    cyc();
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL tick_width: got %b expected 0", frame_tick); end
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL tick_idle: got %0d expected %0d", state, S_IDLE); end
    vsync = 1'b1;
    repeat (4) cyc();
    $display("[TB] test_frame_tick done");
  endtask

  task automatic test_start_serve();
    press_start();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL start_state: got %0d expected %0d", state, S_SERVE); end
    tests++; if (ball_reset !== 1'b1) begin fails++; $display("FAIL start_ball_reset: got %b expected 1", ball_reset); end
    cyc();
    tests++; if (ball_reset !== 1'b0) begin fails++; $display("FAIL start_ball_reset_width: got %b expected 0", ball_reset); end
    tests++; if (physics_en !== 1'b0) begin fails++; $display("FAIL serve_physics: got %b expected 0", physics_en); end
    send_frame();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL serve_hold: got %0d expected %0d after 1 tick", state, S_SERVE); end
    send_frame();
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL serve_to_play: got %0d expected %0d after 2 ticks", state, S_PLAY); end
    tests++; if (physics_en !== 1'b1) begin fails++; $display("FAIL play_physics: got %b expected 1", physics_en); end
    $display("[TB] test_start_serve done");
  endtask

  task automatic test_point();
    goal_right = 1'b1;
    cyc();
    goal_right = 1'b0;
    tests++; if (state !== S_POINT) begin fails++; $display("FAIL point_state: got %0d expected %0d", state, S_POINT); end
    tests++; if (player1_score !== 8'd1 || player2_score !== 8'd0) begin fails++; $display("FAIL point_scores: got %0d/%0d expected 1/0", player1_score, player2_score); end
    tests++; if (serve_dir !== 1'b1) begin fails++; $display("FAIL point_serve_dir: got %b expected 1", serve_dir); end
    tests++; if (physics_en !== 1'b0) begin fails++; $display("FAIL point_physics: got %b expected 0", physics_en); end
    send_frame();
    tests++; if (state !== S_POINT) begin fails++; $display("FAIL point_hold: got %0d expected %0d", state, S_POINT); end
    send_frame();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL point_to_serve: got %0d expected %0d", state, S_SERVE); end
    tests++; if (ball_reset !== 1'b1) begin fails++; $display("FAIL point_ball_reset: got %b expected 1", ball_reset); end
    cyc();
    tests++; if (ball_reset !== 1'b0) begin fails++; $display("FAIL point_ball_reset_width: got %b expected 0", ball_reset); end
    $display("[TB] test_point done");
  endtask

  task automatic test_both_goals();
    send_frame();
    send_frame();
    tests++; if (state !== S_PLAY) begin fails++; $display("FAIL both_setup: got %0d expected %0d", state, S_PLAY); end
    goal_left = 1'b1;
    goal_right = 1'b1;
    cyc();
    goal_left = 1'b0;
    goal_right = 1'b0;
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL both_state: got %0d expected %0d", state, S_SERVE); end
    tests++; if (player1_score !== 8'd1 || player2_score !== 8'd0) begin fails++; $display("FAIL both_scores: got %0d/%0d expected 1/0", player1_score, player2_score); end
    tests++; if (serve_dir !== 1'b1) begin fails++; $display("FAIL both_serve_dir: got %b expected 1", serve_dir); end
    tests++; if (ball_reset !== 1'b1) begin fails++; $display("FAIL both_ball_reset: got %b expected 1", ball_reset); end
    cyc();
    tests++; if (ball_reset !== 1'b0) begin fails++; $display("FAIL both_ball_reset_width: got %b expected 0", ball_reset); end
    $display("[TB] test_both_goals done");
  endtask

  task automatic test_win();
    logic [7:0] exp_p2;
    for (int i = 1; i <= 3; i++) begin
      exp_p2 = 8'(i);
      send_frame();
      tests++; if (state !== S_SERVE) begin fails++; $display("FAIL win_serve_hold%0d: got %0d expected %0d", i, state, S_SERVE); end
      send_frame();
      tests++; if (state !== S_PLAY) begin fails++; $display("FAIL win_play%0d: got %0d expected %0d", i, state, S_PLAY); end
      goal_left = 1'b1;
      cyc();
      goal_left = 1'b0;
      tests++; if (player2_score !== exp_p2 || serve_dir !== 1'b0) begin fails++; $display("FAIL win_score%0d: got p2=%0d dir=%b expected p2=%0d dir=0", i, player2_score, serve_dir, exp_p2); end
      send_frame();
      send_frame();
      if (i < 3) begin
        tests++; if (state !== S_SERVE) begin fails++; $display("FAIL win_reserve%0d: got %0d expected %0d", i, state, S_SERVE); end
      end else begin
        tests++; if (state !== S_OVER) begin fails++; $display("FAIL win_game_over: got %0d expected %0d", state, S_OVER); end
        tests++; if (winner !== 2'b10) begin fails++; $display("FAIL win_winner: got %b expected 10", winner); end
      end
    end
    goal_left = 1'b1;
    cyc();
    goal_left = 1'b0;
    goal_right = 1'b1;
    cyc();
    goal_right = 1'b0;
    send_frame();
    tests++; if (player1_score !== 8'd1 || player2_score !== 8'd3) begin fails++; $display("FAIL over_goals_ignored: got %0d/%0d expected 1/3", player1_score, player2_score); end
    tests++; if (state !== S_OVER || physics_en !== 1'b0) begin fails++; $display("FAIL over_hold: got state %0d phys %b expected %0d/0", state, physics_en, S_OVER); end
    press_start();
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL over_to_idle: got %0d expected %0d", state, S_IDLE); end
    cyc();
    goal_right = 1'b1;
    cyc();
    goal_right = 1'b0;
    tests++; if (player1_score !== 8'd1) begin fails++; $display("FAIL idle_goal_ignored: got %0d expected 1", player1_score); end
    press_start();
    tests++; if (state !== S_SERVE || player1_score !== 8'd0 || player2_score !== 8'd0 || winner !== 2'b00 || serve_dir !== 1'b0) begin
      fails++; $display("FAIL rematch_clear: got st=%0d p1=%0d p2=%0d win=%b dir=%b expected 1/0/0/00/0", state, player1_score, player2_score, winner, serve_dir);
    end
    $display("[TB] test_win done");
  endtask

  task automatic test_start_held_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL held_start: got %0d expected %0d", state, S_IDLE); end
    start = 1'b0;
    cyc();
    press_start();
    tests++; if (state !== S_SERVE) begin fails++; $display("FAIL held_repress: got %0d expected %0d", state, S_SERVE); end
    cyc();
    $display("[TB] test_start_held_reset done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      send_frame();
      send_frame();
      goal_right = 1'b1;
      cyc();
      goal_right = 1'b0;
      send_frame();
      send_frame();
    end
    send_frame();
    send_frame();
    tests++; if (state !== S_PLAY || player1_score !== 8'd2) begin fails++; $display("FAIL async_setup: got st=%0d p1=%0d expected %0d/2", state, player1_score, S_PLAY); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL async_state: got %0d expected %0d", state, S_IDLE); end
    tests++; if (player1_score !== 8'd0 || player2_score !== 8'd0) begin fails++; $display("FAIL async_scores: got %0d/%0d expected 0/0", player1_score, player2_score); end
    tests++; if (physics_en !== 1'b0) begin fails++; $display("FAIL async_physics: got %b expected 0", physics_en); end
    cyc();
    rst = 1'b0;
    cyc();
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_start_serve();
    test_point();
    test_both_goals();
    test_win();
    test_start_held_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
